// File: rtl/host_mem_arbiter_if.sv
// Bundles the N-requester OBI side and the single host-memory OBI side of host_mem_arbiter.
// slave = arbiter view, master = view of whatever drives requesters and memory.
interface host_mem_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]    s_req_i;
  logic [NUM_REQ-1:0]    s_we_i;
  logic [NUM_REQ*4-1:0]  s_be_i;
  logic [NUM_REQ*32-1:0] s_addr_i;
  logic [NUM_REQ*32-1:0] s_wdata_i;
  logic [NUM_REQ-1:0]    s_gnt_o;
  logic [NUM_REQ-1:0]    s_rvalid_o;
  logic [31:0]           s_rdata_o;

  logic                  m_req_o;
  logic                  m_we_o;
  logic [3:0]            m_be_o;
  logic [31:0]           m_addr_o;
  logic [31:0]           m_wdata_o;
  logic                  m_gnt_i;
  logic                  m_rvalid_i;
  logic [31:0]           m_rdata_i;

  modport slave (
    input  s_req_i, s_we_i, s_be_i, s_addr_i, s_wdata_i,
    input  m_gnt_i, m_rvalid_i, m_rdata_i,
    output s_gnt_o, s_rvalid_o, s_rdata_o,
    output m_req_o, m_we_o, m_be_o, m_addr_o, m_wdata_o
  );

  modport master (
    output s_req_i, s_we_i, s_be_i, s_addr_i, s_wdata_i,
    output m_gnt_i, m_rvalid_i, m_rdata_i,
    input  s_gnt_o, s_rvalid_o, s_rdata_o,
    input  m_req_o, m_we_o, m_be_o, m_addr_o, m_wdata_o
  );
endinterface

// File: rtl/host_mem_arbiter.sv
// Round-robin OBI arbiter onto one host port; zero added latency both ways, blocks requests while the ID FIFO is full.
// Optional HOST_MEM_ARB_PERF_EN adds saturating per-requester handshake and stall counters.
module host_mem_arbiter #(
  parameter int NUM_REQ         = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  host_mem_arbiter_if.slave      bus,
  output logic                   err_o
`ifdef HOST_MEM_ARB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]  perf_cnt_o,
  output logic [31:0]            perf_stall_o
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = $clog2(MAX_OUTSTANDING);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(MAX_OUTSTANDING);

  typedef enum logic {ARB, HOLD} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]   hold_sel_q, hold_sel_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]     cnt_q, cnt_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   id_mem_q [MAX_OUTSTANDING];
  logic [IDX_W-1:0]   id_mem_d [MAX_OUTSTANDING];

  logic [IDX_W:0]     cand;
  logic [IDX_W-1:0]   arb_sel, sel, head;
  logic               arb_found, req_active, fifo_full, fifo_empty;
  logic               m_req, handshake, push, pop;
  logic               m_we;
  logic [3:0]         m_be;
  logic [31:0]        m_addr, m_wdata;
  logic [NUM_REQ-1:0] s_gnt, s_rvalid;

  // Round-robin search starting at rr_ptr_q, wrapping past NUM_REQ-1.
  always_comb begin
    arb_sel   = rr_ptr_q;
    arb_found = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NUM_REQ)) cand = cand - (IDX_W+1)'(NUM_REQ);
      if (!arb_found && bus.s_req_i[cand[IDX_W-1:0]]) begin
        arb_found = 1'b1;
        arb_sel   = cand[IDX_W-1:0];
      end
    end
  end

  always_comb begin
    sel        = (state_q == HOLD) ? hold_sel_q : arb_sel;
    req_active = (state_q == HOLD) || arb_found;
    fifo_full  = (cnt_q == FULL_CNT);
    fifo_empty = (cnt_q == '0);
    m_req      = req_active && !fifo_full;
    handshake  = m_req && bus.m_gnt_i;
    push       = handshake;
    pop        = bus.m_rvalid_i && !fifo_empty;
    head       = id_mem_q[rd_ptr_q];

    m_we    = 1'b0;
    m_be    = '0;
    m_addr  = '0;
    m_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_active && sel == IDX_W'(i)) begin
        m_we    = bus.s_we_i[i];
        m_be    = bus.s_be_i[i*4 +: 4];
        m_addr  = bus.s_addr_i[i*32 +: 32];
        m_wdata = bus.s_wdata_i[i*32 +: 32];
      end
    end

    for (int i = 0; i < NUM_REQ; i++) begin
      s_gnt[i]    = handshake && (sel == IDX_W'(i));
      s_rvalid[i] = pop && (head == IDX_W'(i));
    end
  end

  always_comb begin
    state_d    = state_q;
    hold_sel_d = hold_sel_q;
    rr_ptr_d   = rr_ptr_q;
    case (state_q)
      ARB: begin
        if (m_req && !bus.m_gnt_i) begin
          state_d    = HOLD;
          hold_sel_d = sel;
        end
      end
      HOLD: begin
        if (handshake) state_d = ARB;
      end
      default: state_d = ARB;
    endcase
    if (handshake) begin
      rr_ptr_d = (sel == IDX_W'(NUM_REQ-1)) ? '0 : sel + IDX_W'(1);
    end
  end

  always_comb begin
    id_mem_d = id_mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    err_d    = err_q | (bus.m_rvalid_i && fifo_empty);
    if (push) begin
      id_mem_d[wr_ptr_q] = sel;
      wr_ptr_d           = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + (PTR_W+1)'(1);
      2'b01:   cnt_d = cnt_q - (PTR_W+1)'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ARB;
      rr_ptr_q   <= '0;
      hold_sel_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < MAX_OUTSTANDING; i++) id_mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      hold_sel_q <= hold_sel_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      err_q      <= err_d;
      id_mem_q   <= id_mem_d;
    end
  end

  assign bus.m_req_o    = m_req;
  assign bus.m_we_o     = m_we;
  assign bus.m_be_o     = m_be;
  assign bus.m_addr_o   = m_addr;
  assign bus.m_wdata_o  = m_wdata;
  assign bus.s_gnt_o    = s_gnt;
  assign bus.s_rvalid_o = s_rvalid;
  assign bus.s_rdata_o  = bus.m_rdata_i;
  assign err_o          = err_q;

`ifdef HOST_MEM_ARB_PERF_EN
  logic [31:0] perf_cnt_q [NUM_REQ];
  logic [31:0] perf_cnt_d [NUM_REQ];
  logic [31:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_cnt_d   = perf_cnt_q;
    perf_stall_d = perf_stall_q;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (s_gnt[i] && perf_cnt_q[i] != 32'hFFFF_FFFF) perf_cnt_d[i] = perf_cnt_q[i] + 32'd1;
      perf_cnt_o[i*32 +: 32] = perf_cnt_q[i];
    end
    if (m_req && !bus.m_gnt_i && perf_stall_q != 32'hFFFF_FFFF) perf_stall_d = perf_stall_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NUM_REQ; i++) perf_cnt_q[i] <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_cnt_q   <= perf_cnt_d;
      perf_stall_q <= perf_stall_d;
    end
  end

  assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_host_mem_arbiter.sv
// Randomized and directed bench for host_mem_arbiter against a queue-based reference model.
module tb_host_mem_arbiter;
  localparam int N    = 4;
  localparam int MAXO = 4;

  logic clk_i;
  logic rst_ni;
  logic err;
`ifdef HOST_MEM_ARB_PERF_EN
  logic [N*32-1:0] perf_cnt;
  logic [31:0]     perf_stall;
`endif

  host_mem_arbiter_if #(.NUM_REQ(N)) bus ();

  host_mem_arbiter #(.NUM_REQ(N), .MAX_OUTSTANDING(MAXO)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus),
    .err_o  (err)
`ifdef HOST_MEM_ARB_PERF_EN
    ,
    .perf_cnt_o   (perf_cnt),
    .perf_stall_o (perf_stall)
`endif
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // reference model: outstanding IDs in issue order, round-robin pointer, held requester
  int mq[$];
  int rr;
  bit held;
  int held_id;
  bit merr;
  int glog[$];
  int want_mreq = -1;
  int want_hold = -1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    rr = 0;
    held = 0;
    held_id = 0;
    merr = 0;
  endtask

  function automatic int model_sel(input logic [N-1:0] req);
    if (held) return held_id;
    for (int i = 0; i < N; i++) begin
      if (req[(rr + i) % N]) return (rr + i) % N;
    end
    return -1;
  endfunction

  // one clock cycle: drive at posedge+1, compare at negedge, advance model at posedge
  task automatic step(input logic [N-1:0] req, input logic gnt, input logic rv);
    int sel;
    bit exp_mreq, hs, popm;
    logic [N-1:0] exp_gnt, exp_rv;
    logic [31:0] ea, ed;
    logic [3:0] eb;
    logic ew;
    bus.s_req_i    = req;
    bus.m_gnt_i    = gnt;
    bus.m_rvalid_i = rv;
    bus.s_we_i     = N'($urandom);
    bus.m_rdata_i  = $urandom;
    for (int i = 0; i < N; i++) begin
      bus.s_be_i[i*4 +: 4]     = 4'($urandom);
      bus.s_addr_i[i*32 +: 32] = $urandom;
      bus.s_wdata_i[i*32 +: 32] = $urandom;
    end
    sel = model_sel(req);
    exp_mreq = (sel >= 0) && (mq.size() < MAXO);
    ew = 1'b0; eb = '0; ea = '0; ed = '0;
    if (sel >= 0) begin
      ew = bus.s_we_i[sel];
      eb = bus.s_be_i[sel*4 +: 4];
      ea = bus.s_addr_i[sel*32 +: 32];
      ed = bus.s_wdata_i[sel*32 +: 32];
    end
    hs      = exp_mreq && gnt;
    popm    = rv && (mq.size() > 0);
    exp_gnt = hs ? N'(1 << sel) : '0;
    exp_rv  = popm ? N'(1 << mq[0]) : '0;
    @(negedge clk_i);
    chk("m_req", bus.m_req_o, exp_mreq);
    chk("m_addr", bus.m_addr_o, ea);
    chk("m_wdata", bus.m_wdata_o, ed);
    chk("m_be", bus.m_be_o, eb);
    chk("m_we", bus.m_we_o, ew);
    chk("s_gnt", bus.s_gnt_o, exp_gnt);
    chk("s_rvalid", bus.s_rvalid_o, exp_rv);
    chk("s_rdata", bus.s_rdata_o, bus.m_rdata_i);
    chk("err", err, merr);
    if (want_mreq >= 0) chk("dir_mreq", bus.m_req_o, want_mreq[0]);
    if (want_hold >= 0) chk("hold_addr", bus.m_addr_o, bus.s_addr_i[want_hold*32 +: 32]);
    for (int i = 0; i < N; i++) if (bus.s_gnt_o[i]) glog.push_back(i);
    if (rv && mq.size() == 0) merr = 1;
    if (popm) void'(mq.pop_front());
    if (hs) begin
      mq.push_back(sel);
      rr = (sel + 1) % N;
      held = 0;
    end else if (exp_mreq) begin
      held = 1;
      held_id = sel;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    bus.s_req_i = '0; bus.m_gnt_i = 1'b0; bus.m_rvalid_i = 1'b0;
    rst_ni = 1'b0;
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [N-1:0] rq;
`ifdef HOST_MEM_ARB_PERF_EN
    logic [12:0] gpat;
`endif
    rst_ni = 1'b0;
    bus.s_req_i = '0; bus.s_we_i = '0; bus.s_be_i = '0; bus.s_addr_i = '0; bus.s_wdata_i = '0;
    bus.m_gnt_i = 1'b0; bus.m_rvalid_i = 1'b0; bus.m_rdata_i = '0;
    model_reset();
    #2;
    chk("rst_mreq", bus.m_req_o, 1'b0);
    chk("rst_gnt", bus.s_gnt_o, '0);
    chk("rst_rvalid", bus.s_rvalid_o, '0);
    chk("rst_err", err, 1'b0);
    chk("rst_addr", bus.m_addr_o, '0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // continuous requests, immediate grant, response one cycle later
    glog.delete();
    step(4'hF, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) step(4'hF, 1'b1, 1'b1);
    chk("rr_count", glog.size(), 5);
    for (int k = 0; k < 5; k++) chk("rr_order", glog[k], k % 4);

    // requester 2 held for 5 stalled cycles while requester 0 also asks
    step('0, 1'b0, 1'b1);
    want_hold = 2;
    for (int k = 0; k < 5; k++) step(4'b0101, 1'b0, 1'b0);
    step(4'b0101, 1'b1, 1'b0);
    want_hold = -1;
    chk("hold_gnt", glog[$], 2);
    step(4'b1001, 1'b1, 1'b1);
    chk("after_hold_3", glog[$], 3);
    step(4'b0100, 1'b1, 1'b1);
    step(4'b0011, 1'b1, 1'b1);
    chk("wrap_to_0", glog[$], 0);
    step('0, 1'b0, 1'b1);

    // FIFO full blocks the request even with a same-cycle response
    do_reset();
    for (int k = 0; k < 4; k++) step(4'hF, 1'b1, 1'b0);
    want_mreq = 0;
    step(4'hF, 1'b1, 1'b1);
    want_mreq = 1;
    step(4'hF, 1'b1, 1'b0);
    want_mreq = -1;

    // random traffic
    do_reset();
    for (int k = 0; k < 400; k++) begin
      rq = N'($urandom);
      if (held) rq[held_id] = 1'b1;
      step(rq, ($urandom % 3) != 0, (mq.size() > 0) && $urandom[0]);
    end
    while (mq.size() > 0 && total < 100000) step('0, 1'b0, 1'b1);

    // unexpected response sets a sticky error
    do_reset();
    step('0, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) step('0, 1'b0, 1'b0);
    chk("err_sticky", err, 1'b1);

    // asynchronous reset with two responses outstanding
    step(4'b0011, 1'b1, 1'b0);
    step(4'b0011, 1'b1, 1'b0);
    bus.s_req_i = '0; bus.m_gnt_i = 1'b0; bus.m_rvalid_i = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    chk("arst_err", err, 1'b0);
    chk("arst_mreq", bus.m_req_o, 1'b0);
    chk("arst_gnt", bus.s_gnt_o, '0);
    chk("arst_rvalid", bus.s_rvalid_o, '0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    model_reset();
    step('0, 1'b0, 1'b1);
    step('0, 1'b0, 1'b0);
    chk("post_rst_err", err, 1'b1);

`ifdef HOST_MEM_ARB_PERF_EN
    do_reset();
    gpat = 13'b1111_0111_0110_1;
    for (int k = 0; k < 13; k++) step(4'b0010, gpat[k], mq.size() > 0);
    step('0, 1'b0, mq.size() > 0);
    chk("perf_cnt1", perf_cnt[63:32], 32'd10);
    chk("perf_cnt0", perf_cnt[31:0], 32'd0);
    chk("perf_stall", perf_stall, 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
